wr_outfifo_pack: RTL and testbench

Parametrised output-FIFO writer that packs a stream of two-lane pixel beats (din0/din1) into wide FIFO words. Supports configurable lane width, beats per word and lane order, plus line-end flush with zero padding. It sits between the scaler datapath and the output FIFO write port in the clk_108m domain. The input stream cannot be stalled, so FIFO-full conditions drop whole words and are reported through status outputs.

---
 rtl/wr_outfifo_pack.sv | 208 ++++++++++++++++++++
 tb/tb_wr_outfifo_pack.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_outfifo_pack.sv
// ---------------------------------------------------------------------------
// wr_outfifo_pack
//
// Packs a stream of two-lane pixel beats (din0/din1) into wide words for the
// output FIFO write port. Runs entirely in the clk_108m domain.
//
// A word holds BEATS beats. Slot 0 sits in the most-significant bits and later
// beats fill toward the LSB. A line_end closes the current word early, and any
// unfilled slots are zero. The input stream cannot be stalled. If the FIFO
// reports full when a word completes, the whole word is dropped, ovf is set, and
// the optional drop counter is incremented.
//
// Parameters:
//   DIN_W  width of each input lane
//   BEATS  beats packed per output word (1..8)
//   SWAP   lane order within a beat: 0 = {din0,din1}, 1 = {din1,din0}
//   CNT_W  width of the saturating drop counter
//
// Ports:
//   clk_108m        in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   data_valid      in   beat strobe, at most one beat per cycle
//   din0, din1      in   lane 0 / lane 1 data
//   line_end        in   flush request, with or without data_valid
//   out_fifo_full   in   FIFO programmable-full
//   ovf_clr         in   synchronous clear of ovf
//   out_fifo_wren   out  one-cycle write strobe per word
//   out_fifo_wdata  out  packed word, holds its value between writes
//   out_fifo_last   out  word was closed by line_end (qualified by wren)
//   ovf             out  sticky: at least one word was dropped
//   drop_cnt        out  saturating dropped-word count
//
// Optional feature: define WR_OUTFIFO_DROP_CNT_EN to build the drop_cnt port
// and its counter. Without the macro the port and counter do not exist, and
// ovf behaves the same.
// ---------------------------------------------------------------------------
module wr_outfifo_pack #(
    parameter int DIN_W = 8,
    parameter int BEATS = 2,
    parameter int SWAP  = 0,
    parameter int CNT_W = 16
) (
    input  logic                     clk_108m,
    input  logic                     rst_n,
    input  logic                     data_valid,
    input  logic [DIN_W-1:0]         din0,
    input  logic [DIN_W-1:0]         din1,
    input  logic                     line_end,
    input  logic                     out_fifo_full,
    input  logic                     ovf_clr,
    output logic                     out_fifo_wren,
    output logic [2*DIN_W*BEATS-1:0] out_fifo_wdata,
    output logic                     out_fifo_last,
`ifdef WR_OUTFIFO_DROP_CNT_EN
    output logic [CNT_W-1:0]         drop_cnt,
`endif
    output logic                     ovf
);

    localparam int BEAT_W = 2 * DIN_W;
    localparam int WORD_W = BEAT_W * BEATS;
    // Keep the slot index at least one bit wide so that BEATS=1 still builds.
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    // EMPTY: no beat collected yet (idx==0, accumulator zero).
    // FILL : at least one beat is held in the accumulator.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FILL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   acc_q, acc_d;

    logic [BEAT_W-1:0]   beat;
    logic [WORD_W-1:0]   word_in;    // accumulator with the current beat merged
    logic                complete;   // a word is closed this cycle
    logic                word_last;  // closure caused or accompanied by line_end
    logic                wr_ok;
    logic                drop;

    // -----------------------------------------------------------------------
    // Beat formation and slot insertion
    // -----------------------------------------------------------------------
    assign beat = (SWAP != 0) ? {din1, din0} : {din0, din1};

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so that no path can leave it unassigned and infer a latch.
        word_in = acc_q;
        if (data_valid) begin
            for (int s = 0; s < BEATS; s++) begin
                if (idx_q == IDX_W'(s)) begin
                    word_in[WORD_W-1-s*BEAT_W -: BEAT_W] = beat;
                end
            end
        end
    end

    // A word closes on the final slot, or on line_end. A line_end with a beat
    // includes that beat first, and a lone line_end only flushes a partial word.
    assign complete  = (data_valid && ((idx_q == LAST_IDX) || line_end)) ||
                       (line_end && (state_q == S_FILL));
    assign word_last = complete && line_end;
    assign wr_ok     = complete && !out_fifo_full;
    assign drop      = complete &&  out_fifo_full;

    // -----------------------------------------------------------------------
    // Packing FSM: next-state and accumulator update
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;

        case (state_q)
            S_EMPTY: begin
                if (complete) begin
                    // A single-beat word, or a beat together with line_end.
                    state_d = S_EMPTY;
                    idx_d   = '0;
                    acc_d   = '0;
                end else if (data_valid) begin
                    state_d = S_FILL;
                    idx_d   = idx_q + IDX_W'(1);
                    acc_d   = word_in;
                end
            end
            S_FILL: begin
                if (complete) begin
                    // The word leaves whether it is written or dropped.
                    state_d = S_EMPTY;
                    idx_d   = '0;
                    acc_d   = '0;
                end else if (data_valid) begin
                    idx_d   = idx_q + IDX_W'(1);
                    acc_d   = word_in;
                end
            end
            default: begin
                state_d = S_EMPTY;
                idx_d   = '0;
                acc_d   = '0;
            end
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, and the order of statements does not matter.
    always_ff @(posedge clk_108m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output register: one-cycle strobe, data holds between writes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_108m or negedge rst_n) begin
        if (!rst_n) begin
            out_fifo_wren  <= 1'b0;
            out_fifo_wdata <= '0;
            out_fifo_last  <= 1'b0;
        end else begin
            out_fifo_wren <= wr_ok;
            out_fifo_last <= wr_ok && word_last;
            if (wr_ok) begin
                out_fifo_wdata <= word_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Overflow status
    // -----------------------------------------------------------------------
    // When a drop and ovf_clr occur in the same cycle, the set wins, so no
    // drop is lost from software's view.
    always_ff @(posedge clk_108m or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef WR_OUTFIFO_DROP_CNT_EN
    // Saturating count of dropped words. ovf_clr does not touch it, so it keeps
    // a lifetime total since reset.
    always_ff @(posedge clk_108m or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_wr_outfifo_pack.sv
// ---------------------------------------------------------------------------
// tb_wr_outfifo_pack
//
// Testbench with three instances of wr_outfifo_pack:
//   u2: BEATS=2, SWAP=0, CNT_W=4  (packing, flush, full/drop, saturation)
//   u1: BEATS=1, SWAP=1           (back-to-back writes, lane swap)
//   u4: BEATS=4, SWAP=0           (reset mid-word, wide word)
//
// Stimulus is driven on the falling edge. Each time a word is expected, the
// stimulus pushes it into a per-instance queue, together with the cycle in
// which wren must be seen. A monitor samples 1 ns after every rising edge.
// It pops an entry and compares it when the instance asserts wren, and it
// flags both unexpected writes and late writes.
// ---------------------------------------------------------------------------
module tb_wr_outfifo_pack;

    logic clk_108m = 1'b0;
    logic rst_n;

    always #5 clk_108m = ~clk_108m;

    // u2 signals
    logic        dv2, le2, full2, clr2;
    logic [7:0]  a2, b2;
    logic        wren2, last2, ovf2;
    logic [31:0] wd2;
    logic [3:0]  dc2;
    // u1 signals
    logic        dv1;
    logic [7:0]  a1, b1;
    logic        wren1, last1, ovf1;
    logic [15:0] wd1;
    logic [15:0] dc1;
    // u4 signals
    logic        dv4;
    logic [7:0]  a4, b4;
    logic        wren4, last4, ovf4;
    logic [63:0] wd4;
    logic [15:0] dc4;

    wr_outfifo_pack #(.DIN_W(8), .BEATS(2), .SWAP(0), .CNT_W(4)) u2 (
        .clk_108m(clk_108m), .rst_n(rst_n), .data_valid(dv2),
        .din0(a2), .din1(b2), .line_end(le2), .out_fifo_full(full2),
        .ovf_clr(clr2), .out_fifo_wren(wren2), .out_fifo_wdata(wd2),
        .out_fifo_last(last2),
`ifdef WR_OUTFIFO_DROP_CNT_EN
        .drop_cnt(dc2),
`endif
        .ovf(ovf2)
    );

    wr_outfifo_pack #(.DIN_W(8), .BEATS(1), .SWAP(1), .CNT_W(16)) u1 (
        .clk_108m(clk_108m), .rst_n(rst_n), .data_valid(dv1),
        .din0(a1), .din1(b1), .line_end(1'b0), .out_fifo_full(1'b0),
        .ovf_clr(1'b0), .out_fifo_wren(wren1), .out_fifo_wdata(wd1),
        .out_fifo_last(last1),
`ifdef WR_OUTFIFO_DROP_CNT_EN
        .drop_cnt(dc1),
`endif
        .ovf(ovf1)
    );

    wr_outfifo_pack #(.DIN_W(8), .BEATS(4), .SWAP(0), .CNT_W(16)) u4 (
        .clk_108m(clk_108m), .rst_n(rst_n), .data_valid(dv4),
        .din0(a4), .din1(b4), .line_end(1'b0), .out_fifo_full(1'b0),
        .ovf_clr(1'b0), .out_fifo_wren(wren4), .out_fifo_wdata(wd4),
        .out_fifo_last(last4),
`ifdef WR_OUTFIFO_DROP_CNT_EN
        .drop_cnt(dc4),
`endif
        .ovf(ovf4)
    );

`ifndef WR_OUTFIFO_DROP_CNT_EN
    assign dc2 = '0;
    assign dc1 = '0;
    assign dc4 = '0;
`endif

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb [3][$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expect a word whose completing input is being driven now. It will be
    // seen after the next rising edge.
    task automatic push(input int id, input logic [63:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        e.cyc  = cyc + 1;
        sb[id].push_back(e);
    endtask

    task automatic mon(input int id, input logic wren, input logic [63:0] d, input logic l);
        exp_t e;
        if (wren) begin
            if (sb[id].size() == 0) begin
                check($sformatf("u%0d unexpected wren", id), 64'(wren), 64'd0);
            end else begin
                e = sb[id].pop_front();
                check($sformatf("u%0d wdata", id), d, e.data);
                check($sformatf("u%0d last", id), 64'(l), 64'(e.last));
                check($sformatf("u%0d wren cycle", id), 64'(cyc), 64'(e.cyc));
            end
        end else if (sb[id].size() != 0 && sb[id][0].cyc <= cyc) begin
            e = sb[id].pop_front();
            check($sformatf("u%0d missing wren for %h", id, e.data), 64'(wren), 64'd1);
        end
    endtask

    always @(posedge clk_108m) begin
        cyc = cyc + 1;
        #1;
        mon(0, wren2, 64'(wd2), last2);
        mon(1, wren1, 64'(wd1), last1);
        mon(2, wren4, wd4, last4);
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at the next one)
    // -----------------------------------------------------------------------
    task automatic u2_step(input logic v, input logic [7:0] x, input logic [7:0] y,
                           input logic le, input logic full, input logic clr);
        dv2 = v; a2 = x; b2 = y; le2 = le; full2 = full; clr2 = clr;
        @(negedge clk_108m);
        dv2 = 1'b0; le2 = 1'b0; full2 = 1'b0; clr2 = 1'b0;
    endtask

    task automatic u4_step(input logic [7:0] x, input logic [7:0] y);
        dv4 = 1'b1; a4 = x; b4 = y;
        @(negedge clk_108m);
        dv4 = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        dv2 = 0; le2 = 0; full2 = 0; clr2 = 0; a2 = 0; b2 = 0;
        dv1 = 0; a1 = 0; b1 = 0;
        dv4 = 0; a4 = 0; b4 = 0;

        repeat (3) @(negedge clk_108m);
        check("reset wren2", 64'(wren2), 64'd0);
        check("reset wdata2", 64'(wd2), 64'd0);
        check("reset last2", 64'(last2), 64'd0);
        check("reset ovf2", 64'(ovf2), 64'd0);
        check("reset wdata4", wd4, 64'd0);
`ifdef WR_OUTFIFO_DROP_CNT_EN
        check("reset drop_cnt2", 64'(dc2), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk_108m);

        // Two full beats -> 0x11223344, last=0
        u2_step(1, 8'h11, 8'h22, 0, 0, 0);
        push(0, 64'h1122_3344, 1'b0);
        u2_step(1, 8'h33, 8'h44, 0, 0, 0);
        repeat (2) @(negedge clk_108m);

        // Beat with line_end -> zero padded, last=1. A lone line_end while
        // EMPTY writes nothing.
        push(0, 64'hAABB_0000, 1'b1);
        u2_step(1, 8'hAA, 8'hBB, 1, 0, 0);
        u2_step(0, 8'h00, 8'h00, 1, 0, 0);
        repeat (2) @(negedge clk_108m);

        // Flush from FILL with a lone line_end
        u2_step(1, 8'h9A, 8'hBC, 0, 0, 0);
        push(0, 64'h9ABC_0000, 1'b1);
        u2_step(0, 8'h00, 8'h00, 1, 0, 0);
        repeat (2) @(negedge clk_108m);

        // FIFO full on the completing beat -> dropped, ovf set, count 1
        u2_step(1, 8'h01, 8'h02, 0, 0, 0);
        u2_step(1, 8'h03, 8'h04, 0, 1, 0);
        check("ovf after drop", 64'(ovf2), 64'd1);
`ifdef WR_OUTFIFO_DROP_CNT_EN
        check("drop_cnt after drop", 64'(dc2), 64'd1);
`endif
        // The next word writes normally, starting from slot 0
        u2_step(1, 8'h05, 8'h06, 0, 0, 0);
        push(0, 64'h0506_0708, 1'b0);
        u2_step(1, 8'h07, 8'h08, 0, 0, 0);
        u2_step(0, 8'h00, 8'h00, 0, 0, 1);
        check("ovf after clr", 64'(ovf2), 64'd0);
`ifdef WR_OUTFIFO_DROP_CNT_EN
        check("drop_cnt kept by clr", 64'(dc2), 64'd1);
`endif

        // 20 more single-beat drops -> the 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            u2_step(1, 8'hFF, 8'hFF, 1, 1, 0);
        end
        check("ovf after burst", 64'(ovf2), 64'd1);
`ifdef WR_OUTFIFO_DROP_CNT_EN
        check("drop_cnt saturated", 64'(dc2), 64'd15);
`endif
        u2_step(0, 8'h00, 8'h00, 0, 0, 1);
        check("ovf cleared again", 64'(ovf2), 64'd0);
        // Clear and drop in the same cycle: the set wins
        u2_step(1, 8'hFF, 8'hFF, 1, 1, 1);
        check("ovf set beats clr", 64'(ovf2), 64'd1);
`ifdef WR_OUTFIFO_DROP_CNT_EN
        check("drop_cnt holds at 15", 64'(dc2), 64'd15);
`endif
        // Writes still work after saturation
        push(0, 64'h1234_0000, 1'b1);
        u2_step(1, 8'h12, 8'h34, 1, 0, 0);
        repeat (2) @(negedge clk_108m);

        // BEATS=1, SWAP=1: four back-to-back words 0x3412
        dv1 = 1'b1; a1 = 8'h12; b1 = 8'h34;
        for (int i = 0; i < 4; i++) begin
            push(1, 64'h3412, 1'b0);
            @(negedge clk_108m);
        end
        dv1 = 1'b0;
        repeat (2) @(negedge clk_108m);

        // BEATS=4: partial word, then reset discards it
        u4_step(8'hEE, 8'hEE);
        u4_step(8'hDD, 8'hDD);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_108m);
        check("mid reset wren4", 64'(wren4), 64'd0);
        check("mid reset wdata2", 64'(wd2), 64'd0);
        check("mid reset ovf2", 64'(ovf2), 64'd0);
        check("mid reset wdata1", 64'(wd1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_108m);
        u4_step(8'h01, 8'h02);
        u4_step(8'h03, 8'h04);
        u4_step(8'h05, 8'h06);
        push(2, 64'h0102_0304_0506_0708, 1'b0);
        u4_step(8'h07, 8'h08);
        repeat (4) @(negedge clk_108m);

        check("u2 queue drained", 64'(sb[0].size()), 64'd0);
        check("u1 queue drained", 64'(sb[1].size()), 64'd0);
        check("u4 queue drained", 64'(sb[2].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
